// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Four-core round-robin sequencer that sits upstream of the shared data
//   memory controller. It turns core requests into single-master read or
//   write transactions and drives the controller's 13-bit control word:
//     mem_ctrl[3:0]   DR load enables   (one per core)
//     mem_ctrl[7:4]   AR read enables   (one per core)
//     mem_ctrl[11:8]  data read enables (one per core)
//     mem_ctrl[12]    DRAM write enable
//   A core is told its transaction is complete by a one-cycle done pulse.
//
// Parameters
//   READ_LAT  cycles from the address first being driven to DRAM q valid (1..4)
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req[3:0]  per-core request, held until the matching done pulse
//   wr[3:0]   per-core direction, 1 = write, 0 = read (valid while req is high)
//   mem_ctrl  registered control word to the memory controller
//   done[3:0] one-cycle completion pulse for the served core
//   busy      high in every state except IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [3:0]  wr,
  output logic [12:0] mem_ctrl,
  output logic [3:0]  done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RWAIT,
    S_RCAP,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state, state_d;
  logic [1:0]  grant, grant_d;
  logic [1:0]  ptr, ptr_d;
  logic [2:0]  cnt, cnt_d;
  logic [1:0]  pick;
  logic [3:0]  grant_oh;
  logic [12:0] mem_ctrl_d;
  logic [3:0]  done_d;
  logic        busy_d;

  // Round-robin search: first requesting core after the last one served.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state;
    grant_d = grant;
    ptr_d   = ptr;
    cnt_d   = cnt;
    unique case (state)
      S_IDLE: begin
        // Requests are looked at only here; mid-transaction changes are ignored.
        if (|req) begin
          grant_d = pick;
          ptr_d   = pick;
          state_d = wr[pick] ? S_WRITE : S_RADDR;
        end
      end
      S_RADDR: begin
        cnt_d   = 3'd1;
        state_d = (READ_LAT == 1) ? S_RCAP : S_RWAIT;
      end
      S_RWAIT: begin
        // cnt holds the offset of the current cycle from T0.
        if (cnt == 3'(READ_LAT - 1)) state_d = S_RCAP;
        else                         cnt_d   = cnt + 3'd1;
      end
      S_RCAP:  state_d = S_DONE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that, once registered, they
  // line up exactly with the state they describe.
  assign grant_oh = 4'b0001 << grant_d;

  always_comb begin
    mem_ctrl_d = '0;
    done_d     = '0;
    busy_d     = (state_d != S_IDLE);
    unique case (state_d)
      S_RADDR, S_RWAIT: mem_ctrl_d[7:4] = grant_oh;
      S_RCAP: begin
        mem_ctrl_d[7:4] = grant_oh;
        mem_ctrl_d[3:0] = grant_oh;
      end
      S_WRITE: begin
        mem_ctrl_d[7:4]  = grant_oh;
        mem_ctrl_d[11:8] = grant_oh;
        mem_ctrl_d[12]   = 1'b1;
      end
      S_DONE:  done_d = grant_oh;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Pointer starts at 3 so core 0 wins the first grant.
      state    <= S_IDLE;
      grant    <= '0;
      ptr      <= 2'd3;
      cnt      <= '0;
      mem_ctrl <= '0;
      done     <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      ptr      <= ptr_d;
      cnt      <= cnt_d;
      mem_ctrl <= mem_ctrl_d;
      done     <= done_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Two instances share clock and reset:
//   dut1 with READ_LAT=1 and dut3 with READ_LAT=3. Expected per-cycle
//   {mem_ctrl, done, busy} words are queued when a request is driven and
//   popped one per cycle; an empty queue means the instance must be idle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req1 = '0, wr1 = '0, req3 = '0, wr3 = '0;
  logic [12:0] mc1, mc3;
  logic [3:0]  done1, done3;
  logic        busy1, busy3;

  always #5 clk = ~clk;

  mem_arbiter #(.READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .wr(wr1),
    .mem_ctrl(mc1), .done(done1), .busy(busy1)
  );

  mem_arbiter #(.READ_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .wr(wr3),
    .mem_ctrl(mc3), .done(done3), .busy(busy3)
  );

  typedef struct packed {
    logic [12:0] mc;
    logic [3:0]  dn;
    logic        bsy;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed mc/done/busy=%h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input int dut, input exp_t e);
    if (dut == 1) q1.push_back(e);
    else          q3.push_back(e);
  endtask

  // Read trace: AR for lat cycles, AR+DR, done pulse, one idle cycle.
  task automatic push_read(input int dut, input int g, input int lat);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    for (int i = 0; i < lat; i++) push(dut, '{mc: {1'b0, 4'b0, oh, 4'b0}, dn: 4'b0, bsy: 1'b1});
    push(dut, '{mc: {1'b0, 4'b0, oh, oh}, dn: 4'b0, bsy: 1'b1});
    push(dut, '{mc: 13'h0, dn: oh, bsy: 1'b1});
    push(dut, '{mc: 13'h0, dn: 4'b0, bsy: 1'b0});
  endtask

  // Write trace: AR+data+WE, done pulse, one idle cycle.
  task automatic push_write(input int dut, input int g);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    push(dut, '{mc: {1'b1, oh, oh, 4'b0}, dn: 4'b0, bsy: 1'b1});
    push(dut, '{mc: 13'h0, dn: oh, bsy: 1'b1});
    push(dut, '{mc: 13'h0, dn: 4'b0, bsy: 1'b0});
  endtask

  // One clock: sample after the edge, compare both instances, then let the
  // cores drop req for any done pulse they just saw.
  task automatic step(input string tag);
    exp_t e1, e3;
    @(posedge clk);
    #1;
    e1 = (q1.size() > 0) ? q1.pop_front() : '0;
    e3 = (q3.size() > 0) ? q3.pop_front() : '0;
    check({tag, "/lat1"}, {mc1, done1, busy1}, e1);
    check({tag, "/lat3"}, {mc3, done3, busy3}, e3);
    req1 = req1 & ~done1;
    req3 = req3 & ~done3;
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_lat1", {mc1, done1, busy1}, 18'h0);
    check("reset_lat3", {mc3, done3, busy3}, 18'h0);
    rst_n = 1'b1;
    run("idle", 2);

    // Contention: all four cores, cores 1 and 3 write; order must be 0,1,2,3.
    req1 = 4'b1111;
    wr1  = 4'b1010;
    push_read(1, 0, 1);
    push_write(1, 1);
    push_read(1, 2, 1);
    push_write(1, 3);
    run("contend", 16);
    wr1 = 4'b0000;

    // READ_LAT=3 read by core 3.
    req3 = 4'b1000;
    push_read(3, 3, 3);
    run("lat3_read", 7);

    // Single read by core 2.
    req1 = 4'b0100;
    push_read(1, 2, 1);
    run("read2", 5);

    // Single write by core 0.
    req1 = 4'b0001;
    wr1  = 4'b0001;
    push_write(1, 0);
    run("write0", 4);
    wr1 = 4'b0000;

    // Core 1 drops req and flips wr after grant; read must finish unchanged.
    req1 = 4'b0010;
    push_read(1, 1, 1);
    run("chg_t0", 1);
    req1 = 4'b0000;
    wr1  = 4'b0010;
    run("chg_rest", 5);
    wr1 = 4'b0000;

    // Reset in RCAP of a core-1 read; pointer now points at core 1.
    req1 = 4'b0010;
    push_read(1, 1, 1);
    run("pre_abort", 2);
    q1.delete();
    #2;
    rst_n = 1'b0;
    req1  = 4'b0000;
    #1;
    check("abort_async", {mc1, done1, busy1}, 18'h0);
    @(posedge clk);
    #1;
    check("abort_held", {mc1, done1, busy1}, 18'h0);
    rst_n = 1'b1;
    // Without the pointer reset, core 3 would win here.
    req1 = 4'b1001;
    push_read(1, 0, 1);
    push_read(1, 3, 1);
    run("post_reset", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
